pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline. It generalises the ID-stage load-stall and forward-select logic.
- It keeps its own shadow copy of the EX and MEM destination state, so it does not need ern/mrn/ewreg/mwreg from the datapath.
- New features:
  - multi-cycle multiply, occupying EX for MUL_LAT cycles;
  - configurable branch squash depth;
  - optional hardwired-zero register exclusion.
- Sits beside the ID decoder. Drives the IF/ID write enable, the EX hold, the squash and the ID-stage forward selects.

Parameters:
- RW, 5, register address width.
- MUL_LAT, 3, cycles a mul/muli occupies EX (range 1..15; 1 means single-cycle).
- BR_SLOTS, 1, number of younger instructions squashed on a taken branch (range 1..2).
- ZERO_REG, 1, when 1, register 0 never creates a dependency.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- id_valid, in, 1, ID holds a real instruction.
- id_rs, in, RW, ID source A.
- id_rt, in, RW, ID source B.
- id_rs_used, in, 1, source A read as a register.
- id_rt_used, in, 1, source B read as a register (includes store data and branch compare).
- id_wreg, in, 1, instruction writes the register file.
- id_rn, in, RW, destination register.
- id_m2reg, in, 1, load.
- id_mul, in, 1, multi-cycle multiply.
- id_branch, in, 1, conditional branch (beq/bne).
- ex_br_taken, in, 1, branch condition true, computed in EX.
- stall, out, 1, freezes PC and IF/ID (we_pc_ir = ~stall).
- ex_hold, out, 1, EX pipeline register holds its contents.
- squash, out, 1, IF/ID contents become a bubble.
- fwd_a, out, 2, source A select: 00 regfile, 01 EX result, 10 MEM result, 11 reserved.
- fwd_b, out, 2, source B select, same encoding.
- mul_busy, out, 1, mul countdown is non-zero.

Behaviour:
- Shadow stages:
  - E = {v, wreg, rn, m2reg, mul, branch}; M = {v, wreg, rn, m2reg}.
  - Reset clears all v bits, mul_cnt=0, sq_cnt=0. After reset: stall=0, ex_hold=0, squash=0, fwd_a=fwd_b=00, mul_busy=0.
- Match rule: src matches stage X when used & X.v & X.wreg & (X.rn==src) & ~(ZERO_REG & src==0).
- Forwarding (combinational from ID fields and E/M):
  - E match gives 01, else M match gives 10, else 00.
  - E has priority over M. MEM result includes load data.
- Load-use: an E match where E.m2reg=1 on either source sets stall=1. E advances normally, so a bubble enters E next cycle.
- Multiply:
  - When an instruction with mul=1 enters E, mul_cnt loads MUL_LAT-1.
  - While mul_cnt!=0: ex_hold=1, stall=1, mul_busy=1; E is unchanged; M receives a bubble; mul_cnt decrements each cycle.
  - When mul_cnt==0 the mul leaves E the next cycle. Its result is forwardable as 01 in that final cycle.
- Branch:
  - Taken when E.v & E.branch & ex_br_taken & ~ex_hold.
  - squash=1 that cycle, and sq_cnt loads BR_SLOTS-1. squash stays 1 while sq_cnt!=0, then sq_cnt decrements.
  - A squashed ID instruction enters E as a bubble regardless of id_valid.
- Priority:
  - squash overrides stall: a squashed instruction is never stalled and never records a dependency.
  - ex_hold overrides the load stall.
  - A taken branch cannot coincide with ex_hold, because a branch is never a mul.
- E update each cycle:
  - if ex_hold: E holds;
  - else if squash | stall | ~id_valid: E.v=0;
  - else E takes the ID fields.
- M update: M takes E when ~ex_hold, otherwise M.v=0.
- Reset mid-multiply or mid-squash: everything clears on the next edge with no residual stall.
- Counters use 4 bits. Values wrap only through the reload; decrement stops at 0.

Test Plan:
- RAW chain: "add r3,r1,r2" then "sub r4,r3,r5" -> in the sub's ID cycle fwd_a=01, fwd_b=00, stall=0. A third instruction "or r6,r7,r3" gets fwd_b=10.
- Load-use: "lw r8,0(r1)" then "add r9,r8,r8" -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=10. No stall when the consumer is two instructions behind.
- Zero register: "addi r0,r0,5" then "add r2,r0,r0" -> fwd 00, no stall. Repeat with ZERO_REG=0 -> fwd_a=fwd_b=01.
- Multiply, MUL_LAT=3: "mul r5,r1,r2" then "add r6,r5,r5" -> ex_hold=stall=mul_busy=1 for 2 cycles. The following cycle fwd_a=fwd_b=01 and M sees 2 bubbles. Repeat with MUL_LAT=1 -> no stall.
- Branch, BR_SLOTS=2: taken beq in E with ex_br_taken=1 -> squash=1 for 2 consecutive cycles and 2 bubbles enter E. With ex_br_taken=0 -> squash stays 0.
- Reset during multiply: assert reset when mul_cnt=1 -> on the next cycle stall=ex_hold=mul_busy=0, fwd=00, and all shadow valids are 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID-stage hazard, stall, squash and forwarding controller
module pipe_hazard_ctrl #(
    parameter int RW       = 5,
    parameter int MUL_LAT  = 3,
    parameter int BR_SLOTS = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_wreg,
    input  logic [RW-1:0] id_rn,
    input  logic          id_m2reg,
    input  logic          id_mul,
    input  logic          id_branch,
    input  logic          ex_br_taken,
    output logic          stall,
    output logic          ex_hold,
    output logic          squash,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          mul_busy
);

    localparam logic [3:0] MUL_RELOAD = 4'(MUL_LAT - 1);
    localparam logic [3:0] SQ_RELOAD  = 4'(BR_SLOTS - 1);

    // Shadow copy of what currently sits in EX and MEM.
    logic          e_v, e_wreg, e_m2reg, e_branch;
    logic [RW-1:0] e_rn;
    logic          m_v, m_wreg, m_m2reg;
    logic [RW-1:0] m_rn;
    logic [3:0]    mul_cnt;
    logic [3:0]    sq_cnt;

    logic br_taken;
    logic a_e, a_m, b_e, b_m;
    logic load_use;
    logic e_load;

    // A source depends on a stage when that stage writes the same register;
    // register 0 is optionally treated as constant and never matches.
    function automatic logic src_match(input logic used, input logic [RW-1:0] src,
                                       input logic v, input logic wreg,
                                       input logic [RW-1:0] rn);
        return used & v & wreg & (rn == src) & ~((ZERO_REG != 0) && (src == '0));
    endfunction

    // Hazard detection, forward selection and EX admission decision.
    always_comb begin
        ex_hold  = (mul_cnt != 4'd0);
        mul_busy = ex_hold;
        br_taken = e_v & e_branch & ex_br_taken & ~ex_hold;
        squash   = br_taken | (sq_cnt != 4'd0);

        a_e = src_match(id_rs_used, id_rs, e_v, e_wreg, e_rn);
        a_m = src_match(id_rs_used, id_rs, m_v, m_wreg, m_rn);
        b_e = src_match(id_rt_used, id_rt, e_v, e_wreg, e_rn);
        b_m = src_match(id_rt_used, id_rt, m_v, m_wreg, m_rn);

        fwd_a = a_e ? 2'b01 : (a_m ? 2'b10 : 2'b00);
        fwd_b = b_e ? 2'b01 : (b_m ? 2'b10 : 2'b00);

        // A squashed instruction is discarded, so its load-use hazard is moot.
        load_use = (a_e | b_e) & e_m2reg;
        stall    = ex_hold | (load_use & ~squash);
        e_load   = id_valid & ~ex_hold & ~squash & ~stall;
    end

    // EX and MEM shadow stages advance unless a multiply holds EX.
    always_ff @(posedge clock) begin
        if (reset) begin
            e_v      <= 1'b0;
            e_wreg   <= 1'b0;
            e_rn     <= '0;
            e_m2reg  <= 1'b0;
            e_branch <= 1'b0;
            m_v      <= 1'b0;
            m_wreg   <= 1'b0;
            m_rn     <= '0;
            m_m2reg  <= 1'b0;
        end else begin
            if (!ex_hold) begin
                m_v     <= e_v;
                m_wreg  <= e_wreg;
                m_rn    <= e_rn;
                m_m2reg <= e_m2reg;
            end else begin
                m_v <= 1'b0;
            end

            if (e_load) begin
                e_v      <= 1'b1;
                e_wreg   <= id_wreg;
                e_rn     <= id_rn;
                e_m2reg  <= id_m2reg;
                e_branch <= id_branch;
            end else if (!ex_hold) begin
                e_v <= 1'b0;
            end
        end
    end

    // Multiply occupancy and branch-squash countdowns.
    always_ff @(posedge clock) begin
        if (reset) begin
            mul_cnt <= 4'd0;
            sq_cnt  <= 4'd0;
        end else begin
            if (e_load && id_mul) begin
                mul_cnt <= MUL_RELOAD;
            end else if (mul_cnt != 4'd0) begin
                mul_cnt <= mul_cnt - 4'd1;
            end

            if (br_taken) begin
                sq_cnt <= SQ_RELOAD;
            end else if (sq_cnt != 4'd0) begin
                sq_cnt <= sq_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl (two configurations)
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_rs_used, id_rt_used, id_wreg, id_m2reg, id_mul, id_branch;
    logic [4:0] id_rs, id_rt, id_rn;
    logic       ex_br_taken;

    logic [1:0] o_stall, o_hold, o_sq, o_busy;
    logic [1:0] o_fa [2];
    logic [1:0] o_fb [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.RW(5), .MUL_LAT(3), .BR_SLOTS(1), .ZERO_REG(1)) d0 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg), .id_rn(id_rn),
        .id_m2reg(id_m2reg), .id_mul(id_mul), .id_branch(id_branch), .ex_br_taken(ex_br_taken),
        .stall(o_stall[0]), .ex_hold(o_hold[0]), .squash(o_sq[0]), .fwd_a(o_fa[0]),
        .fwd_b(o_fb[0]), .mul_busy(o_busy[0]));

    pipe_hazard_ctrl #(.RW(5), .MUL_LAT(1), .BR_SLOTS(2), .ZERO_REG(0)) d1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wreg(id_wreg), .id_rn(id_rn),
        .id_m2reg(id_m2reg), .id_mul(id_mul), .id_branch(id_branch), .ex_br_taken(ex_br_taken),
        .stall(o_stall[1]), .ex_hold(o_hold[1]), .squash(o_sq[1]), .fwd_a(o_fa[1]),
        .fwd_b(o_fb[1]), .mul_busy(o_busy[1]));

    // Reference model: one record for the instruction in EX (with its remaining
    // extra EX cycles), one for the instruction in MEM, and remaining squash slots.
    int cfg_mul_lat [2] = '{3, 1};
    int cfg_br      [2] = '{1, 2};
    bit cfg_zr      [2] = '{1'b1, 1'b0};

    bit x_v [2], x_wreg [2], x_ld [2], x_br [2];
    int x_rn [2], x_left [2];
    bit w_v [2], w_wreg [2];
    int w_rn [2];
    int sq_left [2];

    bit exp_stall [2], exp_hold [2], exp_sq [2];
    int exp_fa [2], exp_fb [2];

    function automatic bit hits(bit used, int src, bit v, bit wreg, int rn, bit zr);
        return used && v && wreg && (rn == src) && !(zr && src == 0);
    endfunction

    function automatic int sel(bit in_ex, bit in_mem);
        if (in_ex) return 1;
        if (in_mem) return 2;
        return 0;
    endfunction

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            bit ae, am, be, bm, taken;
            ae = hits(id_rs_used, int'(id_rs), x_v[k], x_wreg[k], x_rn[k], cfg_zr[k]);
            am = hits(id_rs_used, int'(id_rs), w_v[k], w_wreg[k], w_rn[k], cfg_zr[k]);
            be = hits(id_rt_used, int'(id_rt), x_v[k], x_wreg[k], x_rn[k], cfg_zr[k]);
            bm = hits(id_rt_used, int'(id_rt), w_v[k], w_wreg[k], w_rn[k], cfg_zr[k]);
            exp_hold[k]  = x_left[k] > 0;
            taken        = x_v[k] && x_br[k] && ex_br_taken && !exp_hold[k];
            exp_sq[k]    = taken || sq_left[k] > 0;
            exp_fa[k]    = sel(ae, am);
            exp_fb[k]    = sel(be, bm);
            exp_stall[k] = exp_hold[k] || ((ae || be) && x_ld[k] && !exp_sq[k]);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit taken;
            taken = x_v[k] && x_br[k] && ex_br_taken && !exp_hold[k];
            if (reset) begin
                x_v[k] = 0; x_left[k] = 0; w_v[k] = 0; sq_left[k] = 0;
            end else begin
                if (exp_hold[k]) begin
                    x_left[k]--;
                    w_v[k] = 0;
                end else begin
                    w_v[k] = x_v[k]; w_wreg[k] = x_wreg[k]; w_rn[k] = x_rn[k];
                    if (exp_sq[k] || exp_stall[k] || !id_valid) begin
                        x_v[k] = 0;
                    end else begin
                        x_v[k] = 1; x_wreg[k] = id_wreg; x_rn[k] = int'(id_rn);
                        x_ld[k] = id_m2reg; x_br[k] = id_branch;
                        x_left[k] = id_mul ? cfg_mul_lat[k] - 1 : 0;
                    end
                end
                if (taken) sq_left[k] = cfg_br[k] - 1;
                else if (sq_left[k] > 0) sq_left[k]--;
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input int expv);
        n_checks++;
        assert (obs === 4'(expv)) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic sample();
        #1;
        model_eval();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("stall%0d", k), 4'(o_stall[k]), int'(exp_stall[k]));
            check($sformatf("ex_hold%0d", k), 4'(o_hold[k]), int'(exp_hold[k]));
            check($sformatf("mul_busy%0d", k), 4'(o_busy[k]), int'(exp_hold[k]));
            check($sformatf("squash%0d", k), 4'(o_sq[k]), int'(exp_sq[k]));
            check($sformatf("fwd_a%0d", k), 4'(o_fa[k]), exp_fa[k]);
            check($sformatf("fwd_b%0d", k), 4'(o_fb[k]), exp_fb[k]);
        end
    endtask

    task automatic advance();
        @(posedge clock);
        model_step();
        @(negedge clock);
        cyc++;
    endtask

    task automatic ins(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input bit wr, input int rn, input bit ld, input bit mul, input bit br);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rs_used = rsu; id_rt_used = rtu;
        id_wreg = wr; id_rn = 5'(rn); id_m2reg = ld; id_mul = mul; id_branch = br;
    endtask

    initial begin
        reset = 1'b1;
        ex_br_taken = 1'b0;
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            x_v[k] = 0; x_left[k] = 0; w_v[k] = 0; sq_left[k] = 0;
            x_wreg[k] = 0; x_ld[k] = 0; x_br[k] = 0; x_rn[k] = 0; w_wreg[k] = 0; w_rn[k] = 0;
        end
        @(negedge clock);
        sample();
        check("rst_stall", 4'(o_stall[0]), 0);
        check("rst_fwd_a", 4'(o_fa[0]), 0);
        advance();
        reset = 1'b0;

        // RAW chain
        ins(1, 1, 2, 1, 1, 1, 3, 0, 0, 0); sample(); advance();
        ins(1, 3, 5, 1, 1, 1, 4, 0, 0, 0); sample();
        check("raw_fa", 4'(o_fa[0]), 1); check("raw_fb", 4'(o_fb[0]), 0);
        check("raw_stall", 4'(o_stall[0]), 0); advance();
        ins(1, 7, 3, 1, 1, 1, 6, 0, 0, 0); sample();
        check("raw_mem_fb", 4'(o_fb[0]), 2); advance();

        // Load-use: one stall, then MEM forwarding
        ins(1, 1, 0, 1, 0, 1, 8, 1, 0, 0); sample(); advance();
        ins(1, 8, 8, 1, 1, 1, 9, 0, 0, 0); sample();
        check("lu_stall", 4'(o_stall[0]), 1); advance();
        sample();
        check("lu_release", 4'(o_stall[0]), 0);
        check("lu_fa", 4'(o_fa[0]), 2); check("lu_fb", 4'(o_fb[0]), 2); advance();
        ins(1, 1, 0, 1, 0, 1, 10, 1, 0, 0); sample(); advance();
        ins(1, 1, 2, 1, 1, 1, 11, 0, 0, 0); sample(); advance();
        ins(1, 10, 10, 1, 1, 1, 12, 0, 0, 0); sample();
        check("lu2_stall", 4'(o_stall[0]), 0); check("lu2_fa", 4'(o_fa[0]), 2); advance();

        // Zero register
        ins(1, 0, 0, 1, 0, 1, 0, 0, 0, 0); sample(); advance();
        ins(1, 0, 0, 1, 1, 1, 2, 0, 0, 0); sample();
        check("zr_fa", 4'(o_fa[0]), 0); check("zr_stall", 4'(o_stall[0]), 0);
        check("nozr_fa", 4'(o_fa[1]), 1); check("nozr_fb", 4'(o_fb[1]), 1); advance();

        // Multiply
        ins(1, 1, 2, 1, 1, 1, 5, 0, 1, 0); sample(); advance();
        ins(1, 5, 5, 1, 1, 1, 6, 0, 0, 0); sample();
        check("mul_hold1", 4'(o_hold[0]), 1); check("mul_stall1", 4'(o_stall[0]), 1);
        check("mul1_stall", 4'(o_stall[1]), 0); check("mul1_fa", 4'(o_fa[1]), 1); advance();
        sample(); check("mul_busy2", 4'(o_busy[0]), 1); advance();
        sample();
        check("mul_done", 4'(o_stall[0]), 0);
        check("mul_fa", 4'(o_fa[0]), 1); check("mul_fb", 4'(o_fb[0]), 1); advance();
        ins(1, 5, 0, 1, 0, 0, 0, 0, 0, 0); sample();
        check("mul_mem_fa", 4'(o_fa[0]), 2); advance();

        // Branch taken, then not taken
        ins(1, 1, 2, 1, 1, 0, 0, 0, 0, 1); sample(); advance();
        ins(1, 1, 2, 1, 1, 1, 13, 0, 0, 0); ex_br_taken = 1'b1; sample();
        check("br_sq0", 4'(o_sq[0]), 1); check("br_sq1", 4'(o_sq[1]), 1); advance();
        ex_br_taken = 1'b0; sample();
        check("br_sq0_end", 4'(o_sq[0]), 0); check("br_sq1_2nd", 4'(o_sq[1]), 1); advance();
        sample(); check("br_sq1_end", 4'(o_sq[1]), 0); advance();
        ins(1, 1, 2, 1, 1, 0, 0, 0, 0, 1); sample(); advance();
        ins(1, 1, 2, 1, 1, 1, 13, 0, 0, 0); sample();
        check("nbr_sq1", 4'(o_sq[1]), 0); advance();

        // Reset in the last hold cycle of a multiply
        ins(1, 1, 2, 1, 1, 1, 5, 0, 1, 0); sample(); advance();
        ins(1, 5, 5, 1, 1, 1, 6, 0, 0, 0); sample(); advance();
        sample(); check("rmul_busy", 4'(o_busy[0]), 1);
        reset = 1'b1; advance(); reset = 1'b0;
        sample();
        check("rmul_stall", 4'(o_stall[0]), 0); check("rmul_hold", 4'(o_hold[0]), 0);
        check("rmul_fa", 4'(o_fa[0]), 0); check("rmul_fb", 4'(o_fb[0]), 0); advance();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit mul, ld, br;
            mul = ($urandom % 7) == 0;
            ld  = !mul && ($urandom % 4) == 0;
            br  = !mul && !ld && ($urandom % 6) == 0;
            ins($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), !br && ($urandom % 10) < 7,
                $urandom_range(0, 3), ld, mul, br);
            ex_br_taken = 1'($urandom);
            reset = ($urandom % 60) == 0;
            sample();
            advance();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
